// File: rtl/rv_core_pkg.sv
// Shared fetch-path types and constants for the core front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv_core_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // One buffered fetch: the returned instruction word and the address it came from.
    typedef struct packed {
        logic [XLEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] addr;
    } fetch_entry_t;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pf_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush.
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: a push is accepted while full only together with a pop; a push+pop while empty is a no-op (the entry is consumed by the bypass path).
module pf_fifo
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Qualify push/pop so the storage can never overflow or underflow.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && !(empty && pop) && (!full || pop);
    end

    // Storage write; no reset needed because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: PC generation, pipelined ROM fetch, DEPTH-entry buffer, jump flush.
// Latency: rvalid to inst_valid_o is 1 cycle, or 0 cycles when built with IF_PREFETCH_BYPASS_EN.
// Backpressure: inst_ready_i=0 holds the head; issue stalls once buffered + in-flight reaches DEPTH.
module if_prefetch
    import rv_core_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            rom_req_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic            rom_gnt_i,
    input  logic            rom_rvalid_i,
    input  logic [XLEN-1:0] rom_rdata_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o
);

    localparam int            CW  = cnt_width(DEPTH);
    localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   pending_nxt;
    logic [CW-1:0]   discard_nxt;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] rsp_addr;
    logic            fire;
    logic            rsp_keep;
    logic            bypass_hit;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Every in-flight request already owns a buffer slot, so a response can always be pushed.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, pending};
    assign rom_req_o  = !rst && !jump_en_i && !fifo_full && (occupancy < CAP);
    assign rom_addr_o = pc;
    assign fire       = rom_req_o && rom_gnt_i;

    // With no stale responses outstanding, the oldest in-flight request sits 4*pending behind pc.
    assign rsp_addr   = pc - (XLEN'(pending) << 2);
    assign rsp_keep   = rom_rvalid_i && (discard == '0) && !jump_en_i;

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass_hit = fifo_empty && rsp_keep;
`else
    assign bypass_hit = 1'b0;
`endif

    assign inst_valid_o = !rst && !jump_en_i && (!fifo_empty || bypass_hit);
    assign push         = rsp_keep && !(bypass_hit && inst_ready_i);
    assign pop          = inst_valid_o && inst_ready_i && !fifo_empty;

    // Pack the returned word with the address it was fetched from.
    always_comb begin
        push_entry      = '0;
        push_entry.inst = rom_rdata_i;
        push_entry.addr = rsp_addr;
    end

    pf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (jump_en_i),
        .wr_data (push_entry),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output mux: NOP and zero address whenever nothing valid is presented.
    always_comb begin
        inst_o      = XLEN'(INST_NOP);
        inst_addr_o = '0;
`ifdef IF_PREFETCH_BYPASS_EN
        if (bypass_hit) begin
            inst_o      = rom_rdata_i;
            inst_addr_o = rsp_addr;
        end else if (inst_valid_o) begin
            inst_o      = head.inst;
            inst_addr_o = head.addr;
        end
`else
        if (inst_valid_o) begin
            inst_o      = head.inst;
            inst_addr_o = head.addr;
        end
`endif
    end

    // In-flight bookkeeping; a jump marks everything still outstanding after this cycle as stale.
    always_comb begin
        pending_nxt = pending;
        if (fire) begin
            pending_nxt = pending_nxt + 1'b1;
        end
        if (rom_rvalid_i) begin
            pending_nxt = pending_nxt - 1'b1;
        end
        discard_nxt = discard;
        if (jump_en_i) begin
            discard_nxt = pending_nxt;
        end else if (rom_rvalid_i && (discard != '0)) begin
            discard_nxt = discard - 1'b1;
        end
    end

    // PC and counter registers; a jump realigns the target to a word boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_ADDR;
            pending <= '0;
            discard <= '0;
        end else begin
            pending <= pending_nxt;
            discard <= discard_nxt;
            if (jump_en_i) begin
                pc <= {jump_addr_i[XLEN-1:2], 2'b00};
            end else if (fire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
module tb_if_prefetch;

`ifdef IF_PREFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    logic        gnt_en;
    logic        rsp_en;
    int          grant_cnt;
    logic [31:0] rom_q[$];

    int checks = 0;
    int errors = 0;

    if_prefetch #(
        .XLEN       (32),
        .DEPTH      (4),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign rom_gnt_i = rom_req_o && gnt_en;

    // ROM model: in-order responses, earliest one cycle after the grant, gated by rsp_en.
    always @(posedge clk) begin
        if (rst) begin
            rom_q.delete();
            rom_rvalid_i <= 1'b0;
            rom_rdata_i  <= '0;
            grant_cnt    <= 0;
        end else begin
            if (rom_rvalid_i) void'(rom_q.pop_front());
            if (rom_req_o && rom_gnt_i) begin
                rom_q.push_back(rom_addr_o);
                grant_cnt <= grant_cnt + 1;
            end
            if (rsp_en && rom_q.size() > 0) begin
                rom_rvalid_i <= 1'b1;
                rom_rdata_i  <= rom_word(rom_q[0]);
            end else begin
                rom_rvalid_i <= 1'b0;
                rom_rdata_i  <= '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 6 && !inst_valid_o; i++) tick();
    endtask

    logic [31:0] exp_addr;
    logic [31:0] prev_addr;
    logic        prev_hold;
    int          accepted;

    initial begin
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0;
        inst_ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
        tick(); tick();
        chk("rst_req",   rom_req_o,    32'd0);
        chk("rst_vld",   inst_valid_o, 32'd0);
        chk("rst_inst",  inst_o,       32'h13);
        chk("rst_iaddr", inst_addr_o,  32'd0);

        // Back-to-back streaming with ready=1
        rst = 1'b0; #1;
        chk("t1_req0",  rom_req_o,    32'd1);
        chk("t1_addr0", rom_addr_o,   32'h0);
        chk("t1_vld0",  inst_valid_o, 32'd0);
        tick();
        chk("t1_addr1", rom_addr_o,   32'h4);
        chk("t1_vld1",  inst_valid_o, 32'(BYP));
        for (int n = 2; n < 7; n++) begin
            tick();
            chk("t1_raddr", rom_addr_o,   32'(4 * n));
            chk("t1_vld",   inst_valid_o, 32'd1);
            chk("t1_iaddr", inst_addr_o,  32'(4 * (n - LAT)));
            chk("t1_inst",  inst_o,       rom_word(32'(4 * (n - LAT))));
        end

        // Back-pressure: fill to DEPTH, then drain in order
        rst = 1'b1; inst_ready_i = 1'b0; tick(); tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("t2_grants", grant_cnt,    32'd4);
        chk("t2_req",    rom_req_o,    32'd0);
        chk("t2_vld",    inst_valid_o, 32'd1);
        chk("t2_head",   inst_addr_o,  32'h0);
        chk("t2_inst",   inst_o,       rom_word(32'h0));
        inst_ready_i = 1'b1; #1;
        chk("t2_d0", inst_addr_o, 32'h0);
        tick();
        chk("t2_d1",     inst_addr_o, 32'h4);
        chk("t2_resume", rom_req_o,   32'd1);
        chk("t2_raddr",  rom_addr_o,  32'h10);
        tick();
        chk("t2_d2", inst_addr_o, 32'h8);
        tick();
        chk("t2_d3", inst_addr_o, 32'hC);
        tick();
        chk("t2_d4", inst_addr_o, 32'h10);

        // Jump with two buffered entries and two requests in flight
        rst = 1'b1; inst_ready_i = 1'b0; rsp_en = 1'b1; tick(); tick();
        rst = 1'b0;
        tick();
        tick(); rsp_en = 1'b0;
        tick();
        tick();
        chk("t3_stall", rom_req_o,    32'd0);
        chk("t3_head",  inst_addr_o,  32'h0);
        jump_en_i = 1'b1; jump_addr_i = 32'h100; rsp_en = 1'b1; #1;
        chk("t3_jvld",  inst_valid_o, 32'd0);
        chk("t3_jinst", inst_o,       32'h13);
        chk("t3_jreq",  rom_req_o,    32'd0);
        tick(); jump_en_i = 1'b0; #1;
        chk("t3_raddr", rom_addr_o,   32'h100);
        chk("t3_vld5",  inst_valid_o, 32'd0);
        tick();
        chk("t3_vld6",  inst_valid_o, 32'd0);
        tick();
        chk("t3_vld7",  inst_valid_o, 32'(BYP));
        wait_valid();
        chk("t3_vld",   inst_valid_o, 32'd1);
        chk("t3_iaddr", inst_addr_o,  32'h100);
        chk("t3_inst",  inst_o,       rom_word(32'h100));
        inst_ready_i = 1'b1;
        tick();
        chk("t3_next",  inst_addr_o,  32'h104);

        // Jump coinciding with a response and an available grant
        rst = 1'b1; inst_ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; tick(); tick();
        rst = 1'b0;
        tick();
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0203; #1;
        chk("t4_req",  rom_req_o,    32'd0);
        chk("t4_vld",  inst_valid_o, 32'd0);
        chk("t4_inst", inst_o,       32'h13);
        tick(); jump_en_i = 1'b0; #1;
        chk("t4_raddr", rom_addr_o,   32'h200);
        chk("t4_vld2",  inst_valid_o, 32'd0);
        wait_valid();
        chk("t4_vld3",  inst_valid_o, 32'd1);
        chk("t4_iaddr", inst_addr_o,  32'h200);
        chk("t4_idata", inst_o,       rom_word(32'h200));

        // Random handshake delays, back-pressure and jumps against a sequence scoreboard
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        exp_addr = 32'h0; accepted = 0; prev_hold = 1'b0; prev_addr = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            inst_ready_i = ($urandom_range(0, 3) != 0);
            gnt_en       = ($urandom_range(0, 1) != 0);
            rsp_en       = ($urandom_range(0, 2) != 0);
            jump_en_i    = ($urandom_range(0, 19) == 0);
            jump_addr_i  = $urandom;
            #1;
            if (prev_hold && !jump_en_i) begin
                chk("rnd_hold_req",  rom_req_o,  32'd1);
                chk("rnd_hold_addr", rom_addr_o, prev_addr);
            end
            if (jump_en_i) begin
                chk("rnd_jump_vld", inst_valid_o, 32'd0);
            end
            if (!inst_valid_o) begin
                chk("rnd_nop",   inst_o,      32'h13);
                chk("rnd_zaddr", inst_addr_o, 32'h0);
            end else if (inst_ready_i) begin
                chk("rnd_seq",  inst_addr_o, exp_addr);
                chk("rnd_data", inst_o,      rom_word(exp_addr));
                exp_addr = exp_addr + 32'd4;
                accepted++;
            end
            if (jump_en_i) exp_addr = {jump_addr_i[31:2], 2'b00};
            prev_hold = rom_req_o && !rom_gnt_i;
            prev_addr = rom_addr_o;
            tick();
        end
        jump_en_i = 1'b0;
        chk("rnd_progress", 32'(accepted > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the core's single-word fetch stage.
- Generates the PC and issues pipelined requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their addresses in a DEPTH-entry prefetch FIFO, and presents them to the IF/ID register with a valid/ready handshake.
- Handles jump redirects by flushing buffered and in-flight fetches; sits between the instruction ROM and if_id.

Parameters:
- XLEN, 32, width of address and instruction words.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2; also bounds in-flight requests.
- RESET_ADDR, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_req_o  out  1  fetch request valid.
- rom_addr_o  out  XLEN  fetch address; word aligned.
- rom_gnt_i  in  1  request accepted this cycle.
- rom_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after gnt.
- rom_rdata_i  in  XLEN  response instruction.
- jump_en_i  in  1  redirect request from ex.
- jump_addr_i  in  XLEN  redirect target.
- inst_valid_o  out  1  inst_o and inst_addr_o are valid.
- inst_ready_i  in  1  downstream accepts this cycle.
- inst_o  out  XLEN  instruction; reads as NOP 32'h0000_0013 whenever inst_valid_o=0.
- inst_addr_o  out  XLEN  instruction address; reads 0 whenever inst_valid_o=0.

Behaviour:
- Reset: pc=RESET_ADDR, FIFO empty, pending=0, discard=0. rom_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0.
  - Reset mid-operation drops all in-flight responses. The memory side must be reset in the same cycle.
- Counters:
  - pending = number of granted requests not yet answered, width $clog2(DEPTH)+1.
  - discard = number of those pending requests whose responses are stale.
  - discard ≤ pending at all times.
- Issue:
  - rom_req_o = !rst && !jump_en_i && (fifo_count + pending < DEPTH).
  - rom_addr_o = pc.
  - On req && gnt: pc <= pc+4 (mod 2^XLEN, wraps silently) and pending increments.
  - While req=1 and gnt=0, rom_addr_o holds stable. A jump is the only event that may withdraw the request.
- Response:
  - On rvalid with discard>0: discard decrements and the data is dropped.
  - On rvalid with discard=0: {rom_rdata_i, pc_of_request} is pushed into the FIFO.
  - The request address is tracked by a DEPTH-deep address queue, or equivalently fetch_pc minus 4*pending.
  - Either way, pending decrements.
  - Because issue is bounded by capacity, a push can never overflow the FIFO. The verifier asserts this.
- Output:
  - Head of FIFO is presented; inst_valid_o = !empty.
  - Pop on inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle is legal when full or empty; count is unchanged.
  - Latency without bypass: rvalid cycle N, inst_valid_o cycle N+1.
- Jump (jump_en_i=1 in cycle N):
  - FIFO flushed.
  - inst_valid_o is forced to 0 combinationally in cycle N.
  - pc <= jump_addr_i & ~3.
  - discard <= pending_next, where pending_next includes any rvalid decrement in cycle N. No grant is possible in cycle N because req is masked.
  - Fetch resumes at cycle N+1.
  - An rvalid in cycle N is dropped.
- Simultaneous events: jump takes priority over push and pop. A pop in the jump cycle is not counted, because valid is forced low.
- Back-pressure: inst_ready_i=0 holds the FIFO head stable. Issue stalls once fifo_count + pending reaches DEPTH.

Optional Feature:
- IF_PREFETCH_BYPASS_EN defined:
  - If the FIFO is empty, discard=0, rvalid=1 and no jump, the response drives the outputs combinationally in the same cycle. inst_valid_o=1.
  - If inst_ready_i=1 that cycle, nothing is pushed; otherwise it is pushed.
  - Zero-cycle fetch-to-output latency.
- Not defined: every response goes through the FIFO, giving 1-cycle latency and no combinational path from rom_rdata_i to inst_o.

Decomposition:
- Package rv_core_pkg:
  - INST_NOP = 32'h0000_0013.
  - XLEN default.
  - clog2-based counter-width helper.
  - struct fetch_entry_t {inst, addr}.
- Sub-module pf_fifo: synchronous FIFO of fetch_entry_t, DEPTH parameter, with push, pop, flush, count, full and empty.
- Top if_prefetch holds the PC, pending/discard counters and output muxing.

Test Plan:
- Reset release, ROM with 1-cycle gnt and rvalid the cycle after gnt, ready=1: addresses 0x0, 0x4, 0x8 issued back to back; inst_valid_o from cycle 3 onward, with inst_addr_o incrementing by 4.
- inst_ready_i=0 for 20 cycles, DEPTH=4: exactly 4 requests granted, FIFO full, rom_req_o=0; head stays at addr 0x0. Releasing ready drains 0x0..0xC in order, then issue resumes.
- Jump to 0x100 while pending=2 and FIFO holds 2 entries: inst_valid_o=0 that cycle; both late responses dropped; next output addr is 0x100 with data from ROM[0x100].
- Jump in the same cycle as rvalid and gnt=1: rom_req_o=0 that cycle, the response is dropped, discard correct, no stale instruction appears.
- Random gnt/rvalid delays (0–3 cycles) with random ready and random jumps: scoreboard checks that output addresses are sequential from each jump target, with no overflow, loss or duplication. inst_o=0x13 whenever inst_valid_o=0.
- With IF_PREFETCH_BYPASS_EN, empty FIFO and ready=1: rvalid in cycle N gives inst_valid_o=1 in the same cycle N. Without the macro, it appears in cycle N+1.
